// File: rtl/fpu_issue_queue_if.sv
// Bundle of the channel request, issue, flag-report and status signals
// between the requesters/FPU core and the issue queue.
interface fpu_issue_queue_if #(
   parameter int NUM_CH = 4,
   parameter int DEPTH  = 8,
   parameter int EXP_W  = 8,
   parameter int MAN_W  = 23
);
   localparam int INSTR_W = 5 + 2 * (1 + EXP_W + MAN_W);
   localparam int CH_W    = $clog2(NUM_CH);
   localparam int CNT_W   = $clog2(DEPTH + 1);

   logic [NUM_CH-1:0]         req_valid;
   logic [NUM_CH-1:0]         req_ready;
   logic [NUM_CH*INSTR_W-1:0] req_instr;
   logic                      issue_valid;
   logic                      issue_ready;
   logic [INSTR_W-1:0]        issue_instr;
   logic [CH_W-1:0]           issue_ch;
   logic                      res_valid;
   logic [CH_W-1:0]           res_ch;
   logic [7:0]                res_flags;
   logic [NUM_CH-1:0]         flag_clr;
   logic [NUM_CH*9-1:0]       sticky_flags;
   logic [CNT_W-1:0]          count;
   logic                      full;
   logic                      empty;

   // Requesters / FPU core side
   modport master (
      output req_valid, req_instr, issue_ready, res_valid, res_ch, res_flags, flag_clr,
      input  req_ready, issue_valid, issue_instr, issue_ch, sticky_flags, count, full, empty
   );

   // Issue queue side
   modport slave (
      input  req_valid, req_instr, issue_ready, res_valid, res_ch, res_flags, flag_clr,
      output req_ready, issue_valid, issue_instr, issue_ch, sticky_flags, count, full, empty
   );
endinterface

// File: rtl/fpu_issue_queue.sv
// Multi-channel FPU front end: round-robin admission of one instruction per
// cycle into a shared first-word-fall-through FIFO, with sticky per-channel
// exception flags fed by FPU results and illegal-opcode rejections.
module fpu_issue_queue #(
   parameter int NUM_CH = 4,
   parameter int DEPTH  = 8,
   parameter int EXP_W  = 8,
   parameter int MAN_W  = 23
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   fpu_issue_queue_if.slave io_q
);
   localparam int INSTR_W = 5 + 2 * (1 + EXP_W + MAN_W);
   localparam int CH_W    = $clog2(NUM_CH);
   localparam int CNT_W   = $clog2(DEPTH + 1);
   localparam int PTR_W   = $clog2(DEPTH);
   localparam int ENT_W   = CH_W + INSTR_W;

   // Maps rr + offset back into the channel range without a divider.
   function automatic logic [CH_W-1:0] f_wrap(input logic [CH_W:0] v);
      if (v >= (CH_W+1)'(NUM_CH)) return CH_W'(v - (CH_W+1)'(NUM_CH));
      else                        return v[CH_W-1:0];
   endfunction

   logic                r_active;
   logic [CH_W-1:0]     r_rr;
   logic [PTR_W-1:0]    r_wr_ptr;
   logic [PTR_W-1:0]    r_rd_ptr;
   logic [CNT_W-1:0]    r_count;

   logic                w_full;
   logic                w_empty;
   logic                w_pop;
   logic                w_push_ok;
   logic                w_grant;
   logic [CH_W-1:0]     w_gnt_idx;
   logic [NUM_CH-1:0]   w_req_ready;
   logic [INSTR_W-1:0]  w_gnt_instr;
   logic                w_legal;
   logic                w_push;
   logic                w_illegal;
   logic [INSTR_W-1:0]  w_req_instr [NUM_CH];
   logic [ENT_W-1:0]    w_mem [DEPTH];
   logic [ENT_W-1:0]    w_head;

   assign w_full    = (r_count == CNT_W'(DEPTH));
   assign w_empty   = (r_count == '0);
   assign w_pop     = !w_empty && io_q.issue_ready;
   // r_active keeps admission closed until the first edge after reset release.
   assign w_push_ok = r_active && (!w_full || w_pop);

   genvar gi;
   generate
      for (gi = 0; gi < NUM_CH; gi++) begin : g_req
         assign w_req_instr[gi] = io_q.req_instr[gi*INSTR_W +: INSTR_W];
      end
   endgenerate

   // Round-robin search starting at rr; first valid channel wins.
   always_comb begin
      w_grant     = 1'b0;
      w_gnt_idx   = '0;
      w_req_ready = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         if (!w_grant && w_push_ok &&
             io_q.req_valid[f_wrap({1'b0, r_rr} + (CH_W+1)'(k))]) begin
            w_grant   = 1'b1;
            w_gnt_idx = f_wrap({1'b0, r_rr} + (CH_W+1)'(k));
         end
      end
      if (w_grant) w_req_ready[w_gnt_idx] = 1'b1;
   end

   assign w_gnt_instr = w_req_instr[w_gnt_idx];
   // Opcodes 4..7 have the MSB set and are rejected after the handshake.
   assign w_legal     = !w_gnt_instr[INSTR_W-1];
   assign w_push      = w_grant && w_legal;
   assign w_illegal   = w_grant && !w_legal;

   // Control state: active flag, round-robin pointer, FIFO pointers and occupancy.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_active <= 1'b0;
         r_rr     <= '0;
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         r_active <= 1'b1;
         if (w_grant)
            r_rr <= (w_gnt_idx == CH_W'(NUM_CH - 1)) ? '0 : w_gnt_idx + CH_W'(1);
         if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         if (w_push && !w_pop)      r_count <= r_count + CNT_W'(1);
         else if (w_pop && !w_push) r_count <= r_count - CNT_W'(1);
      end
   end

   // FIFO storage: entries are reset so the head never reads X after reset.
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_mem
         logic [ENT_W-1:0] r_entry;
         // Capture the granted instruction and its channel tag at the write slot.
         always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n)
               r_entry <= '0;
            else if (w_push && (r_wr_ptr == PTR_W'(gi)))
               r_entry <= {w_gnt_idx, w_gnt_instr};
         end
         assign w_mem[gi] = r_entry;
      end
   endgenerate

   assign w_head           = w_mem[r_rd_ptr];
   assign io_q.issue_valid = !w_empty;
   assign io_q.issue_instr = w_head[INSTR_W-1:0];
   assign io_q.issue_ch    = w_head[INSTR_W +: CH_W];
   assign io_q.req_ready   = w_req_ready;
   assign io_q.count       = r_count;
   assign io_q.full        = w_full;
   assign io_q.empty       = w_empty;

   // Sticky flags per channel: new bits win over a same-cycle clear.
   generate
      for (gi = 0; gi < NUM_CH; gi++) begin : g_flags
         logic [8:0] r_sticky;
         logic [8:0] w_set;
         assign w_set[8]   = w_illegal && (w_gnt_idx == CH_W'(gi));
         assign w_set[7:0] = (io_q.res_valid && (io_q.res_ch == CH_W'(gi))) ?
                             io_q.res_flags : 8'h00;
         // Accumulate result/illegal bits; a clear keeps only this cycle's bits.
         always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n)                r_sticky <= '0;
            else if (io_q.flag_clr[gi]) r_sticky <= w_set;
            else                         r_sticky <= r_sticky | w_set;
         end
         assign io_q.sticky_flags[gi*9 +: 9] = r_sticky;
      end
   endgenerate
endmodule

// File: doc/fpu_issue_queue.md
Name: fpu_issue_queue

Overview:
- Parametrised multi-channel front end for the FPU.
- Up to NUM_CH requesters each present an FPU instruction (opcode, rmode, opa, opb). A round-robin arbiter admits one per cycle into a shared first-word-fall-through FIFO, which issues to the FPU core with a valid/ready handshake.
- The block also keeps sticky per-channel exception flags, built from FPU results and from illegal-opcode rejections.

Parameters:
- NUM_CH, 4, number of requesting channels (≥2).
- DEPTH, 8, FIFO entries (power of 2, ≥2).
- EXP_W, 8, operand exponent width.
- MAN_W, 23, operand mantissa width.
- Derived: INSTR_W = 5 + 2*(1+EXP_W+MAN_W), which is 69 at the defaults. CH_W = $clog2(NUM_CH). CNT_W = $clog2(DEPTH+1).

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- req_valid  in  NUM_CH  per-channel request valid
- req_ready  out  NUM_CH  per-channel accept (at most one bit high)
- req_instr  in  NUM_CH*INSTR_W  per-channel instruction; channel i occupies slice [i*INSTR_W +: INSTR_W]; fields MSB→LSB: fpu_op[2:0], rmode[1:0], opa, opb
- issue_valid  out  1  head entry valid
- issue_ready  in  1  FPU core accepts the head entry
- issue_instr  out  INSTR_W  head instruction
- issue_ch  out  CH_W  originating channel of the head entry
- res_valid  in  1  FPU result flag report valid
- res_ch  in  CH_W  channel the result belongs to
- res_flags  in  8  {inf, snan, qnan, ine, overflow, underflow, zero, div_by_zero}, bit 7 down to bit 0
- flag_clr  in  NUM_CH  per-channel sticky clear
- sticky_flags  out  NUM_CH*9  per channel: {illegal_op, res_flags[7:0]}
- count  out  CNT_W  FIFO occupancy
- full  out  1  count == DEPTH
- empty  out  1  count == 0

Behaviour:
- Reset (reset low, asynchronous):
  - FIFO read/write pointers, count and sticky_flags go to 0; round-robin pointer rr goes to 0.
  - Outputs during and after reset: issue_valid=0, empty=1, full=0, req_ready=0.
  - Reset mid-operation discards all queued entries. Release is synchronous to clk.
- Push permission: push_ok = !full || pop, where pop = issue_valid && issue_ready. Simultaneous push and pop at full is allowed; count stays unchanged.
- Arbitration (combinational):
  - When push_ok, grant the first channel with req_valid set, searching rr, rr+1, … modulo NUM_CH.
  - req_ready[g]=1 for the granted channel only. No grant when push_ok=0.
  - req_ready depends on req_valid; requesters must not make req_valid depend on req_ready.
- rr update: on a grant, rr ← (g+1) mod NUM_CH at the clock edge; otherwise unchanged.
- Accepted instruction handling:
  - fpu_op ∈ {0..3} (ADD, SUB, MULT, DIV): written to the FIFO with tag g.
  - fpu_op ∈ {4..7}: the handshake completes but nothing is pushed. Sets sticky_flags[g*9+8] (illegal_op). rr advances normally.
- FIFO:
  - First-word-fall-through: issue_valid = !empty; issue_instr and issue_ch reflect the head combinationally from storage.
  - Pop advances the read pointer. Pointers wrap modulo DEPTH.
  - count: +1 on push only, −1 on pop only, unchanged on both or neither.
  - Latency: an instruction accepted at edge N is visible at the head no earlier than after edge N (one cycle when the FIFO was empty).
  - Strict FIFO order across all channels.
- Sticky flags:
  - On res_valid, OR res_flags into the channel res_ch word, bits [7:0].
  - flag_clr[i] zeroes all 9 bits of channel i at the edge.
  - If a set (result or illegal_op) and a clear hit the same channel in the same cycle, the new bits survive: result = new bits only.
  - res_ch ≥ NUM_CH is ignored.
- Issue outputs are not registered separately; issue_instr is don't-care when issue_valid=0 but must not be X after reset.

Test Plan:
1. Reset mid-traffic: count=3, then reset driven low → count=0, empty=1, issue_valid=0, sticky_flags=0, req_ready=0 while low; after release, first grant goes to ch0 when all channels are valid.
2. Round-robin: req_valid=4'b1111 held, issue_ready=1, all legal ops → req_ready one-hot sequence ch0,1,2,3,0; issue_ch follows the same sequence one cycle later.
3. Full/backpressure: issue_ready=0, ch0 pushes 8 legal ops → full=1, count=8, req_ready=0 on the 9th request. Then issue_ready=1 with ch1 valid → pop and push in the same cycle, count stays 8, full stays 1.
4. Illegal op: ch2 sends fpu_op=3'b101 → req_ready[2]=1, count unchanged, sticky_flags[26]=1, rr advances to 3.
5. Flags: res_valid, res_ch=1, res_flags=8'h08, then 8'h01 → channel 1 word = 9'h009. Next cycle flag_clr[1]=1 together with res_flags=8'h02 → 9'h002.
6. Wraparound ordering: 20 legal instructions with distinct opa, random issue_ready → issued in exact acceptance order, pointers wrap twice, count never exceeds 8.
